// File: rtl/issue_hazard_ctrl.sv
// Stall/flush/issue controller for the dual-issue in-order pipeline.
// Resolves load-use bubbles, intra-pair dependency splits, mispredict
// redirects with a programmable flush window, and external memory holds.
module issue_hazard_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned PC_W         = 6,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_hold,
    input  logic             v0_d,
    input  logic             v1_d,
    input  logic [REG_W-1:0] rs0_d,
    input  logic [REG_W-1:0] rt0_d,
    input  logic             use_rt0_d,
    input  logic [REG_W-1:0] rd0_d,
    input  logic             wr0_d,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rt1_d,
    input  logic             use_rt1_d,
    input  logic [REG_W-1:0] rd1_d,
    input  logic             wr1_d,
    input  logic             ld0_e,
    input  logic             ld1_e,
    input  logic [REG_W-1:0] rd0_e,
    input  logic [REG_W-1:0] rd1_e,
    input  logic             mispredict_e,
    input  logic [PC_W-1:0]  target_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             kill0_e,
    output logic             kill1_e,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned FC_W = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SPLIT   = 2'd1,
        ST_REDIR   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    // A one-cycle window needs no extra state; longer windows park in REDIRECT.
    localparam state_t          MISP_ST = (FLUSH_CYCLES > 1) ? ST_REDIR : ST_RUN;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    state_t          state_q;
    state_t          state_nxt;
    logic [FC_W-1:0] fcnt_q;
    logic [FC_W-1:0] fcnt_nxt;
    logic            lu_hit0;
    logic            lu_hit1;
    logic            lu;
    logic            pd;

    // Load-use: an EX load writing a nonzero register read by a valid decode slot.
    assign lu_hit0 = ld0_e && (rd0_e != '0) &&
                     ((v0_d && ((rs0_d == rd0_e) || (use_rt0_d && (rt0_d == rd0_e)))) ||
                      (v1_d && ((rs1_d == rd0_e) || (use_rt1_d && (rt1_d == rd0_e)))));
    assign lu_hit1 = ld1_e && (rd1_e != '0) &&
                     ((v0_d && ((rs0_d == rd1_e) || (use_rt0_d && (rt0_d == rd1_e)))) ||
                      (v1_d && ((rs1_d == rd1_e) || (use_rt1_d && (rt1_d == rd1_e)))));
    assign lu      = lu_hit0 || lu_hit1;

    // Pair dependency: slot1 reads or rewrites slot0's nonzero destination.
    assign pd = v0_d && v1_d && wr0_d && (rd0_d != '0) &&
                ((rs1_d == rd0_d) || (use_rt1_d && (rt1_d == rd0_d)) ||
                 (wr1_d && (rd1_d == rd0_d)));

    assign state = state_q;

    // State and flush-window counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_nxt;
            fcnt_q  <= fcnt_nxt;
        end
    end

    // Next-state: mispredict > hold > load-use > pair split > normal.
    always_comb begin
        state_nxt = state_q;
        fcnt_nxt  = fcnt_q;
        case (state_q)
            ST_ILLEGAL: begin
                state_nxt = ST_RUN;
                fcnt_nxt  = '0;
            end
            default: begin
                if (mispredict_e) begin
                    state_nxt = MISP_ST;
                    fcnt_nxt  = FC_LOAD;
                end else if (state_q == ST_REDIR) begin
                    // Hold freezes the window, stretching flush_d by the hold length.
                    if (!ext_hold) begin
                        if (fcnt_q <= FC_W'(1)) begin
                            state_nxt = ST_RUN;
                            fcnt_nxt  = '0;
                        end else begin
                            fcnt_nxt = fcnt_q - FC_W'(1);
                        end
                    end
                end else if (ext_hold || lu) begin
                    state_nxt = state_q;
                end else if (state_q == ST_SPLIT) begin
                    state_nxt = ST_RUN;
                end else if (pd) begin
                    state_nxt = ST_SPLIT;
                end
            end
        endcase
    end

    // Zero-latency control outputs, all forced low while reset is asserted.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        kill0_e     = 1'b0;
        kill1_e     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (reset) begin
            case (state_q)
                ST_ILLEGAL: begin
                    redirect = 1'b0;
                end
                default: begin
                    if (mispredict_e) begin
                        redirect    = 1'b1;
                        redirect_pc = target_e;
                        flush_d     = 1'b1;
                        flush_e     = 1'b1;
                    end else if (state_q == ST_REDIR) begin
                        flush_d = 1'b1;
                    end else if (ext_hold || lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (state_q == ST_SPLIT) begin
                        kill0_e = 1'b1;
                    end else if (pd) begin
                        kill1_e = 1'b1;
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_d && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Self-checking bench for issue_hazard_ctrl (FLUSH_CYCLES=3).
module tb_issue_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned PC_W  = 6;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             ext_hold;
        logic             v0;
        logic             v1;
        logic [REG_W-1:0] rs0;
        logic [REG_W-1:0] rt0;
        logic             urt0;
        logic [REG_W-1:0] rd0;
        logic             wr0;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rt1;
        logic             urt1;
        logic [REG_W-1:0] rd1;
        logic             wr1;
        logic             ld0;
        logic             ld1;
        logic [REG_W-1:0] rd0e;
        logic [REG_W-1:0] rd1e;
        logic             misp;
        logic [PC_W-1:0]  tgt;
    } in_t;

    typedef struct packed {
        logic             stall_f;
        logic             stall_d;
        logic             flush_d;
        logic             flush_e;
        logic             kill0;
        logic             kill1;
        logic             redirect;
        logic [PC_W-1:0]  redirect_pc;
        logic [1:0]       state;
        logic [CNT_W-1:0] stall_cnt;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             ext_hold;
    logic             v0_d, v1_d;
    logic [REG_W-1:0] rs0_d, rt0_d, rd0_d, rs1_d, rt1_d, rd1_d;
    logic             use_rt0_d, wr0_d, use_rt1_d, wr1_d;
    logic             ld0_e, ld1_e;
    logic [REG_W-1:0] rd0_e, rd1_e;
    logic             mispredict_e;
    logic [PC_W-1:0]  target_e;
    logic             stall_f, stall_d, flush_d, flush_e;
    logic             kill0_e, kill1_e, redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    int   checks;
    int   errors;
    int   cnt_model;
    out_t sb[$];
    vec_t vecs[$];

    issue_hazard_ctrl #(
        .REG_W(REG_W), .PC_W(PC_W), .FLUSH_CYCLES(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .ext_hold(ext_hold),
        .v0_d(v0_d), .v1_d(v1_d),
        .rs0_d(rs0_d), .rt0_d(rt0_d), .use_rt0_d(use_rt0_d), .rd0_d(rd0_d), .wr0_d(wr0_d),
        .rs1_d(rs1_d), .rt1_d(rt1_d), .use_rt1_d(use_rt1_d), .rd1_d(rd1_d), .wr1_d(wr1_d),
        .ld0_e(ld0_e), .ld1_e(ld1_e), .rd0_e(rd0_e), .rd1_e(rd1_e),
        .mispredict_e(mispredict_e), .target_e(target_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .kill0_e(kill0_e), .kill1_e(kill1_e), .redirect(redirect),
        .redirect_pc(redirect_pc), .state(state), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(input logic sf, input logic sd, input logic fd,
                               input logic fe, input logic k0, input logic k1,
                               input logic rr, input logic [PC_W-1:0] pc,
                               input logic [1:0] st);
        out_t r;
        r             = '0;
        r.stall_f     = sf;
        r.stall_d     = sd;
        r.flush_d     = fd;
        r.flush_e     = fe;
        r.kill0       = k0;
        r.kill1       = k1;
        r.redirect    = rr;
        r.redirect_pc = pc;
        r.state       = st;
        return r;
    endfunction

    task automatic drive(input in_t i);
        ext_hold     = i.ext_hold;
        v0_d         = i.v0;
        v1_d         = i.v1;
        rs0_d        = i.rs0;
        rt0_d        = i.rt0;
        use_rt0_d    = i.urt0;
        rd0_d        = i.rd0;
        wr0_d        = i.wr0;
        rs1_d        = i.rs1;
        rt1_d        = i.rt1;
        use_rt1_d    = i.urt1;
        rd1_d        = i.rd1;
        wr1_d        = i.wr1;
        ld0_e        = i.ld0;
        ld1_e        = i.ld1;
        rd0_e        = i.rd0e;
        rd1_e        = i.rd1e;
        mispredict_e = i.misp;
        target_e     = i.tgt;
    endtask

    task automatic push_exp(input out_t e);
        out_t x;
        x           = e;
        x.stall_cnt = CNT_W'(cnt_model);
        sb.push_back(x);
    endtask

    task automatic check_now(input string nm);
        out_t a;
        out_t e;
        e = sb.pop_front();
        a = {stall_f, stall_d, flush_d, flush_e, kill0_e, kill1_e, redirect,
             redirect_pc, state, stall_cnt};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (sf sd fd fe k0 k1 rr pc st cnt)", nm, a, e);
        end
    endtask

    // One cycle: drive after the edge, compare on the falling edge, advance the count model.
    task automatic step(input in_t i, input out_t e, input string nm);
        drive(i);
        push_exp(e);
        @(negedge clk);
        check_now(nm);
        if (e.stall_d && cnt_model < 255) cnt_model++;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input in_t i, input out_t e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        in_t  t;
        out_t z;
        out_t bub;
        out_t pdo;
        out_t spl;
        checks    = 0;
        errors    = 0;
        cnt_model = 0;
        reset     = 1'b0;
        drive('0);

        z   = o(0, 0, 0, 0, 0, 0, 0, 6'h00, 2'd0);
        bub = o(1, 1, 0, 1, 0, 0, 0, 6'h00, 2'd0);
        pdo = o(1, 1, 0, 0, 0, 1, 0, 6'h00, 2'd0);
        spl = o(0, 0, 0, 0, 1, 0, 0, 6'h00, 2'd1);

        // Vector table (applied in order, state carries over).
        for (int k = 0; k < 10; k++) add('0, z);
        t = '0; t.ld0 = 1; t.rd0e = 5'd5; t.v1 = 1; t.rs1 = 5'd5; add(t, bub);
        add('0, z);
        t.rd0e = 5'd0; add(t, z);
        t = '0; t.ld1 = 1; t.rd1e = 5'd7; t.v0 = 1; t.rt0 = 5'd7; add(t, z);
        t.urt0 = 1; add(t, bub);
        t = '0; t.ld0 = 1; t.rd0e = 5'd9; t.rs0 = 5'd9; add(t, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd3; t.rs1 = 5'd3; add(t, pdo);
        add('0, spl);
        add('0, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd4; t.wr1 = 1; t.rd1 = 5'd4; add(t, pdo);
        t = '0; t.ld0 = 1; t.rd0e = 5'd2; t.v0 = 1; t.rs0 = 5'd2; add(t, o(1, 1, 0, 1, 0, 0, 0, 6'h00, 2'd1));
        t = '0; t.ext_hold = 1; add(t, o(1, 1, 0, 1, 0, 0, 0, 6'h00, 2'd1));
        add('0, spl);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd0; t.rs1 = 5'd0; add(t, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 0; t.rd0 = 5'd6; t.rs1 = 5'd6; add(t, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd6; t.rs1 = 5'd1; t.rt1 = 5'd6; add(t, z);
        t.urt1 = 1; add(t, pdo);
        add('0, spl);
        t = '0; t.misp = 1; t.tgt = 6'h2A; add(t, o(0, 0, 1, 1, 0, 0, 1, 6'h2A, 2'd0));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, z);
        t = '0; t.misp = 1; t.tgt = 6'h15; t.ext_hold = 1;
        t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd3; t.rs1 = 5'd3;
        add(t, o(0, 0, 1, 1, 0, 0, 1, 6'h15, 2'd0));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        t = '0; t.ext_hold = 1;
        add(t, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add(t, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd3; t.rs1 = 5'd3;
        t.ld0 = 1; t.rd0e = 5'd3; add(t, bub);
        add('0, z);
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd8; t.rs1 = 5'd8; add(t, pdo);
        t = '0; t.misp = 1; t.tgt = 6'h03; add(t, o(0, 0, 1, 1, 0, 0, 1, 6'h03, 2'd1));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, z);
        t = '0; t.misp = 1; t.tgt = 6'h01; add(t, o(0, 0, 1, 1, 0, 0, 1, 6'h01, 2'd0));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        t = '0; t.misp = 1; t.tgt = 6'h02; add(t, o(0, 0, 1, 1, 0, 0, 1, 6'h02, 2'd2));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, o(0, 0, 1, 0, 0, 0, 0, 6'h00, 2'd2));
        add('0, z);
        t = '0; t.ld1 = 1; t.rd1e = 5'd12; t.v1 = 1; t.rt1 = 5'd12; t.urt1 = 1; add(t, bub);
        add('0, z);

        // Outputs low while reset is held.
        #2;
        push_exp(z);
        check_now("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[k]) step(vecs[k].in, vecs[k].exp, $sformatf("vec%0d", k));

        // Long external hold: stall every cycle, counter saturates at 255.
        t = '0; t.ext_hold = 1;
        for (int k = 0; k < 300; k++) step(t, bub, $sformatf("hold%0d", k));
        push_exp(o(0, 0, 0, 0, 0, 0, 0, 6'h00, 2'd0));
        drive('0);
        @(negedge clk);
        check_now("sat_cnt");
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a split.
        t = '0; t.v0 = 1; t.v1 = 1; t.wr0 = 1; t.rd0 = 5'd3; t.rs1 = 5'd3;
        step(t, pdo, "pre_split");
        drive('0);
        #2;
        push_exp(spl);
        check_now("in_split");
        reset = 1'b0;
        cnt_model = 0;
        #1;
        push_exp(z);
        check_now("reset_mid_split");
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        step('0, z, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_hazard_ctrl.md
Name: issue_hazard_ctrl

Overview:
- Central stall/flush/issue controller for the dual-issue in-order pipeline.
- Drives the IF/ID register's stall and flush, the PC hold, the ID/EX bubble insertion, and per-slot kill signals.
- Inputs are decode-stage register fields and EX-stage load/branch status.
- Resolves four conditions:
  - load-use hazards;
  - intra-pair RAW/WAW dependencies, by splitting the pair over two cycles;
  - branch mispredict redirect with a programmable flush window;
  - external memory hold.

Parameters:
REG_W, 5, register specifier width
PC_W, 6, program counter width
FLUSH_CYCLES, 1, cycles flush_d stays asserted after a redirect (1..7)
CNT_W, 8, width of the saturating stall counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
ext_hold  in  1  memory not ready; freeze front end
v0_d  in  1  slot0 valid in decode
v1_d  in  1  slot1 valid in decode
rs0_d  in  REG_W  slot0 source A
rt0_d  in  REG_W  slot0 source B
use_rt0_d  in  1  slot0 reads rt
rd0_d  in  REG_W  slot0 destination
wr0_d  in  1  slot0 writes rd
rs1_d  in  REG_W  slot1 source A
rt1_d  in  REG_W  slot1 source B
use_rt1_d  in  1  slot1 reads rt
rd1_d  in  REG_W  slot1 destination
wr1_d  in  1  slot1 writes rd
ld0_e  in  1  EX slot0 is a load
ld1_e  in  1  EX slot1 is a load
rd0_e  in  REG_W  EX slot0 destination
rd1_e  in  REG_W  EX slot1 destination
mispredict_e  in  1  branch resolved wrong in EX
target_e  in  PC_W  correct PC for redirect
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
flush_d  out  1  clear IF/ID
flush_e  out  1  insert bubble into ID/EX (both slots)
kill0_e  out  1  invalidate slot0 entering ID/EX
kill1_e  out  1  invalidate slot1 entering ID/EX
redirect  out  1  PC mux selects redirect_pc
redirect_pc  out  PC_W  redirect target
state  out  2  FSM state (debug)
stall_cnt  out  CNT_W  saturating count of stall_d cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, flush counter=0, stall_cnt=0.
  - All outputs forced to 0 while reset is low.
- States:
  - RUN=0: normal issue.
  - SPLIT=1: second half of a split pair.
  - REDIRECT=2: flush window.
  - Encoding 3 is illegal and returns to RUN next cycle with all outputs 0.
- Register 0 never creates a hazard.
- Load-use hazard (LU): ld0_e or ld1_e writes a nonzero register matching rs0_d, rt0_d (if use_rt0_d) of a valid slot0, or rs1_d, rt1_d (if use_rt1_d) of a valid slot1.
- Pair dependency (PD): v0_d & v1_d & wr0_d & rd0_d≠0, together with any of:
  - rs1_d==rd0_d;
  - use_rt1_d & rt1_d==rd0_d;
  - wr1_d & rd1_d==rd0_d.
- Priority, highest first: mispredict_e > ext_hold > LU > PD > normal.
- mispredict_e (any state):
  - Same cycle: redirect=1, redirect_pc=target_e, flush_d=1, flush_e=1, stall_f=stall_d=0.
  - If FLUSH_CYCLES>1, enter REDIRECT with counter=FLUSH_CYCLES-1; otherwise stay in or return to RUN.
  - Any pending split is abandoned.
- REDIRECT:
  - flush_d=1, all other outputs 0; counter decrements each cycle.
  - Exits to RUN in the cycle the counter reaches 0.
  - ext_hold freezes the counter.
  - A new mispredict_e reloads the counter.
- ext_hold: stall_f=stall_d=1, flush_e=1 (bubble); state and counters frozen; no flush_d.
- LU, in RUN or SPLIT:
  - Combinational 1-cycle bubble: stall_f=stall_d=1, flush_e=1.
  - State unchanged. Re-evaluated next cycle, so a second dependent load extends the stall.
- PD in RUN (no LU):
  - Issue slot0 only: kill1_e=1, stall_f=stall_d=1.
  - Next state SPLIT.
- SPLIT (no LU, no hold):
  - Issue slot1 only: kill0_e=1, stall_f=stall_d=0.
  - Next state RUN. PD is not re-evaluated in SPLIT.
- Normal: all outputs 0 except stall_cnt.
- stall_cnt increments every cycle stall_d=1 and saturates at 2^CNT_W-1.
- Latency: all control outputs are combinational from inputs plus registered state; zero-cycle response.

Test Plan:
- Release reset, idle inputs -> every output 0, state=0, stall_cnt=0 for 10 cycles; assert reset mid-SPLIT -> state=0 and outputs 0 immediately.
- ld0_e=1, rd0_e=5, v1_d=1, rs1_d=5 -> one cycle of stall_f=stall_d=flush_e=1, then all 0; stall_cnt=1. Same stimulus with rd0_e=0 -> no stall.
- v0_d=v1_d=1, wr0_d=1, rd0_d=3, rs1_d=3 -> cycle1: kill1_e=1, stall_d=1, state=0; cycle2: kill0_e=1, stall_d=0, state=1; cycle3: state=0.
- FLUSH_CYCLES=3, mispredict_e pulse with target_e=6'h2A -> redirect=1, redirect_pc=0x2A, flush_d=flush_e=1; then flush_d=1 for 2 further cycles in state=2; then RUN.
- mispredict_e asserted in the same cycle as PD and ext_hold -> redirect and flushes only, no stall, kills 0; the split is not entered.
- ext_hold held 300 cycles -> stall_d=1 throughout, stall_cnt saturates at 255; hold during REDIRECT freezes the counter (flush_d duration extended by the hold length).
